// File: rtl/instr_mem_pkg.sv
// Shared definitions for the multi-channel instruction memory.
//   state_t    : CLEAR (zero-fill after reset), LOAD (loader owns the array), RUN (cores read)
//   WORD_BYTES : bytes per instruction word; byte addresses are word-aligned on this
//   idx_w()    : word-index width for a given depth
//   addr_fault(): misaligned or beyond-depth byte address (addresses up to 64 bits)
package instr_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_SH    = $clog2(WORD_BYTES);

    function automatic int unsigned idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Range check is done on the full address so high bits never alias
    // onto a valid word index.
    function automatic logic addr_fault(input logic [63:0] addr, input int unsigned depth);
        return (addr[BYTE_SH-1:0] != '0) || ((addr >> BYTE_SH) >= 64'(depth));
    endfunction

endpackage

// File: rtl/instr_mem_mc_if.sv
// Bus bundle between the cores/loader and instr_mem_mc.
//   load_en_i/load_we_i/load_addr_i/load_data_i : loader mode request and write port
//   ready_o                                     : memory is in RUN
//   req_i/addr_i                                : per-channel read request and byte address
//   instr_o/valid_o/fault_o                     : per-channel registered read result
// master = cores/loader side, slave = memory side.
interface instr_mem_mc_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                       load_en_i;
    logic                       load_we_i;
    logic [ADDR_W-1:0]          load_addr_i;
    logic [DATA_W-1:0]          load_data_i;
    logic                       ready_o;
    logic [NUM_CH-1:0]          req_i;
    logic [NUM_CH*ADDR_W-1:0]   addr_i;
    logic [NUM_CH*DATA_W-1:0]   instr_o;
    logic [NUM_CH-1:0]          valid_o;
    logic [NUM_CH-1:0]          fault_o;

    modport master (
        output load_en_i, load_we_i, load_addr_i, load_data_i, req_i, addr_i,
        input  ready_o, instr_o, valid_o, fault_o
    );

    modport slave (
        input  load_en_i, load_we_i, load_addr_i, load_data_i, req_i, addr_i,
        output ready_o, instr_o, valid_o, fault_o
    );
endinterface

// File: rtl/instr_mem_read_port.sv
// One registered read channel of instr_mem_mc.
//   clk_i, rst_i : clock, synchronous active-low reset
//   rd_en        : request accepted this cycle (memory in RUN and req set)
//   addr         : channel byte address
//   rd_data      : array word selected by this channel's truncated index
//   instr/valid/fault : result one cycle after the request; instr holds when idle
module instr_mem_read_port
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] instr,
    output logic              valid,
    output logic              fault
);

    logic bad;

    assign bad = addr_fault(64'(addr), DEPTH);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            instr <= '0;
            valid <= 1'b0;
            fault <= 1'b0;
        end else if (rd_en) begin
            valid <= 1'b1;
            fault <= bad;
            // A faulting read returns NOP rather than the aliased word.
            instr <= bad ? '0 : rd_data;
        end else begin
            valid <= 1'b0;
            fault <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_mem_mc.sv
// Multi-channel instruction memory: one shared word array, written by a
// loader in LOAD, read by NUM_CH registered channels in RUN, zero-filled
// one word per cycle in CLEAR after every reset.
//   clk_i : clock
//   rst_i : synchronous active-low reset
//   bus   : instr_mem_mc_if slave (loader port, ready, per-channel reads)
module instr_mem_mc
    import instr_mem_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_mem_mc_if.slave  bus
);

    localparam int unsigned IDX_W = idx_w(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  clear_cnt;
    logic              clear_last;
    logic              clear_we;
    logic              load_wr;
    logic              run;
    logic [IDX_W-1:0]  load_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign clear_last = (clear_cnt == IDX_W'(DEPTH - 1));
    assign load_idx   = bus.load_addr_i[BYTE_SH +: IDX_W];

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear counter wraps back to 0 on its own since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            clear_cnt <= '0;
        end else if (state == CLEAR) begin
            clear_cnt <= clear_cnt + IDX_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR:   if (clear_last) state_nxt = bus.load_en_i ? LOAD : RUN;
            LOAD:    if (!bus.load_en_i) state_nxt = RUN;
            RUN:     if (bus.load_en_i) state_nxt = LOAD;
            default: state_nxt = CLEAR;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ready_o = 1'b0;
        clear_we    = 1'b0;
        load_wr     = 1'b0;
        run         = 1'b0;
        unique case (state)
            CLEAR:   clear_we = 1'b1;
            LOAD:    load_wr  = bus.load_we_i && !addr_fault(64'(bus.load_addr_i), DEPTH);
            RUN: begin
                bus.ready_o = 1'b1;
                run         = 1'b1;
            end
            default: ;
        endcase
    end

    // Array writes; reset itself leaves contents alone, CLEAR zeroes them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (clear_we) begin
                mem[clear_cnt] <= '0;
            end else if (load_wr) begin
                mem[load_idx] <= bus.load_data_i;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ADDR_W-1:0] ch_addr;
        logic [IDX_W-1:0]  ch_idx;
        logic [DATA_W-1:0] ch_instr;
        logic              ch_valid;
        logic              ch_fault;

        assign ch_addr = bus.addr_i[c*ADDR_W +: ADDR_W];
        assign ch_idx  = ch_addr[BYTE_SH +: IDX_W];

        instr_mem_read_port #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .rd_en   (run && bus.req_i[c]),
            .addr    (ch_addr),
            .rd_data (mem[ch_idx]),
            .instr   (ch_instr),
            .valid   (ch_valid),
            .fault   (ch_fault)
        );

        assign bus.instr_o[c*DATA_W +: DATA_W] = ch_instr;
        assign bus.valid_o[c]                  = ch_valid;
        assign bus.fault_o[c]                  = ch_fault;
    end

endmodule

// File: doc/instr_mem_mc.md
Name: instr_mem_mc

Overview:
- Parametrised, multi-channel successor to the single-port combinational instruction ROM, for the multi-core CPU.
- One shared word array, programmed through a loader port, read by NUM_CH cores through independent registered read ports.
- Adds hardware zero-fill after reset, a load/run mode state machine, one-cycle registered reads with valid, and misaligned/out-of-range fault flags.

Parameters:
- NUM_CH, 2, number of core read channels (1..8).
- DEPTH, 32, number of instruction words; power of two, 4..1024.
- DATA_W, 32, instruction word width.
- ADDR_W, 32, byte-address width of the load and read ports.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- load_en_i  in  1  request load mode.
- load_we_i  in  1  loader write strobe, honoured only in LOAD.
- load_addr_i  in  ADDR_W  loader byte address.
- load_data_i  in  DATA_W  loader write data.
- ready_o  out  1  high only in RUN.
- req_i  in  NUM_CH  per-channel read request.
- addr_i  in  NUM_CH*ADDR_W  per-channel byte address; channel c occupies bits [c*ADDR_W +: ADDR_W].
- instr_o  out  NUM_CH*DATA_W  per-channel instruction, packed the same way.
- valid_o  out  NUM_CH  per-channel read-data valid.
- fault_o  out  NUM_CH  per-channel address fault, qualified by valid_o.

Behaviour:
- Reset (rst_i low at an edge):
  - State becomes CLEAR and the clear counter becomes 0.
  - ready_o=0; valid_o, fault_o and instr_o all 0.
  - Memory is not cleared by reset itself; it is cleared by CLEAR.
- State CLEAR:
  - Writes 0 to word[clear_cnt], one word per cycle; clear_cnt counts 0..DEPTH-1.
  - After the write of word DEPTH-1: go to LOAD if load_en_i=1, else RUN.
  - Lasts exactly DEPTH cycles.
  - load_we_i and req_i are ignored.
- State LOAD:
  - Each cycle with load_we_i=1 writes load_data_i to word[load_addr_i>>2].
  - Writes are dropped silently if load_addr_i[1:0]!=0 or (load_addr_i>>2)>=DEPTH.
  - load_en_i=0 at an edge moves to RUN. A write presented in that same cycle is still performed.
- State RUN:
  - load_en_i=1 at an edge moves to LOAD. Reads presented that cycle complete normally.
  - Memory content persists across LOAD/RUN transitions.
- Read port c:
  - Registered. If state is RUN and req_i[c]=1 at edge N, then after edge N: valid_o[c]=1 and instr_o[c]=word[addr>>2].
  - Read sees memory as of before edge N; reads and writes are never concurrent, since LOAD and RUN are exclusive.
  - Fault when addr[1:0]!=0 or (addr>>2)>=DEPTH: fault_o[c]=1 and instr_o[c]=0 (NOP) with valid_o[c]=1.
  - No request, or state not RUN: valid_o[c]=0, fault_o[c]=0, instr_o[c] holds its last value.
  - Channels are fully independent; any number may read the same word in the same cycle with no stall.
- Index arithmetic: word index = addr>>2 truncated to clog2(DEPTH) bits only after the range check. High address bits are never aliased.
- Reset mid-operation (any state): return to CLEAR; memory is re-zeroed and any outstanding valid is dropped.

Decomposition:
- Package instr_mem_pkg:
  - state enum {CLEAR, LOAD, RUN}.
  - WORD_BYTES=4.
  - IDX_W=clog2(DEPTH) helper.
- Sub-module instr_mem_read_port: one per channel, built with a generate loop. It contains the fault check, the output registers and the valid logic, and is fed the array read data for its index.
- Top level owns the array, the state machine, the clear counter and the loader.

Test Plan:
- Reset then idle, DEPTH=32 -> ready_o rises exactly 32 cycles after rst_i deasserts; a read of address 0x7C returns 0x00000000 with valid=1, fault=0.
- Hold load_en_i=1 through CLEAR; write 0x20080005 to address 0x0 and 0x2009000A to 0x4; drop load_en_i -> ch0 reads 0x4 and ch1 reads 0x0 in the same cycle, and one cycle later return 0x2009000A and 0x20080005 respectively, both valid.
- In RUN, ch0 reads address 0x6 and ch1 reads 0x80 (DEPTH=32) -> both valid=1, fault=1, instr=0. In LOAD, a write to 0x80 is dropped and leaves word 0 unchanged.
- In RUN, req on ch0 and load_en_i=1 in the same cycle -> ch0 read completes (valid=1); state becomes LOAD and ready_o=0; a req in the following cycle gives valid=0 and instr_o held.
- Program word 3 = 0xDEADBEEF, then pulse rst_i low for 1 cycle mid-RUN -> ready_o low for 32 cycles; afterwards address 0xC reads 0x00000000.
- NUM_CH=4, all channels request address 0x8 continuously for 10 cycles -> all four show valid=1 with identical data every cycle, with no gaps.
